// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory responder slice.
// Access sizes, responder FSM states and the bus word width in bytes.
package mem_pkg;

    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD} mem_size_t;

    typedef enum {ST_IDLE, ST_WAIT, ST_RESP} dmem_state_t;

    localparam int WORD_BYTES = 4;

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request/response bus between the core's memory initiator and the responder.
interface dmem_responder_if;
    import mem_pkg::*;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    mem_size_t   req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/mem_lane_align.sv
// Byte-lane steering for one access: store byte enables and lane placement,
// right-justified load extraction and the alignment check.
module mem_lane_align
    import mem_pkg::*;
(
    input  mem_size_t   size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] raw_rdata,
    output logic [3:0]  byte_en,
    output logic [31:0] lane_wdata,
    output logic [31:0] rdata,
    output logic        misalign
);

    // Replicating the store data across lanes lets byte_en alone pick the target lanes.
    always_comb begin
        byte_en    = 4'b0000;
        lane_wdata = wdata;
        rdata      = 32'h0;
        misalign   = 1'b0;
        case (size)
            SZ_BYTE: begin
                byte_en    = 4'b0001 << addr_lo;
                lane_wdata = {4{wdata[7:0]}};
                rdata      = {24'h0, raw_rdata[{addr_lo, 3'b000} +: 8]};
            end
            SZ_HALF: begin
                byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{wdata[15:0]}};
                rdata      = {16'h0, raw_rdata[{addr_lo[1], 4'b0000} +: 16]};
                misalign   = addr_lo[0];
            end
            SZ_WORD: begin
                byte_en    = 4'b1111;
                rdata      = raw_rdata;
                misalign   = (addr_lo != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Word-organised data memory answering core load/stores over a valid/ready
// handshake, with a fixed number of wait states between accept and response.
module dmem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input logic clk,
    input logic rst,
    dmem_responder_if.slave bus
);

    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN_BYTES = 32'(DEPTH_WORDS * WORD_BYTES);
    localparam logic [3:0]  WAIT_INIT  = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    dmem_state_t state, next_state;
    logic        running;
    logic [3:0]  wait_cnt;
    logic        cap_we;
    mem_size_t   cap_size;
    logic [31:0] cap_addr, cap_wdata;
    logic [31:0] rdata_q;
    logic        err_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic             accept, enter_resp, access_err, misalign;
    logic             cur_we;
    mem_size_t        cur_size;
    logic [31:0]      cur_addr, cur_wdata, addr_off;
    logic [IDX_W-1:0] word_idx;
    logic [3:0]       byte_en;
    logic [31:0]      lane_wdata, load_data;

    assign accept     = bus.req_valid && bus.req_ready;
    assign enter_resp = (next_state == ST_RESP) && (state != ST_RESP);

    // With zero wait states the access happens on the accept edge, so use the live request then.
    assign cur_we    = (state == ST_IDLE) ? bus.req_we    : cap_we;
    assign cur_size  = (state == ST_IDLE) ? bus.req_size  : cap_size;
    assign cur_addr  = (state == ST_IDLE) ? bus.req_addr  : cap_addr;
    assign cur_wdata = (state == ST_IDLE) ? bus.req_wdata : cap_wdata;

    assign addr_off   = cur_addr - BASE_ADDR;
    assign word_idx   = addr_off[IDX_W+1:2];
    assign access_err = (cur_size == SZ_RSVD) || misalign || (addr_off >= SPAN_BYTES);

    mem_lane_align u_align (
        .size       (cur_size),
        .addr_lo    (cur_addr[1:0]),
        .wdata      (cur_wdata),
        .raw_rdata  (mem[word_idx]),
        .byte_en    (byte_en),
        .lane_wdata (lane_wdata),
        .rdata      (load_data),
        .misalign   (misalign)
    );

    // running keeps req_ready low until the first clock after reset is released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            running <= 1'b0;
        end else begin
            state   <= next_state;
            running <= 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (accept) next_state = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT: if (wait_cnt == 4'd0) next_state = ST_RESP;
            ST_RESP: if (bus.rsp_ready) next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = 1'b0;
        bus.rsp_valid = 1'b0;
        case (state)
            ST_IDLE: bus.req_ready = running;
            ST_RESP: bus.rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt  <= 4'd0;
            cap_we    <= 1'b0;
            cap_size  <= SZ_BYTE;
            cap_addr  <= 32'h0;
            cap_wdata <= 32'h0;
            rdata_q   <= 32'h0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                cap_we    <= bus.req_we;
                cap_size  <= bus.req_size;
                cap_addr  <= bus.req_addr;
                cap_wdata <= bus.req_wdata;
                wait_cnt  <= WAIT_INIT;
            end else if (state == ST_WAIT && wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (enter_resp) begin
                err_q   <= access_err;
                rdata_q <= (access_err || cur_we) ? 32'h0 : load_data;
            end
        end
    end

    // RAM is deliberately unreset; a store commits only on the edge that enters RESP.
    always_ff @(posedge clk) begin
        if (enter_resp && cur_we && !access_err) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                if (byte_en[i]) mem[word_idx][8*i +: 8] <= lane_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a 2-wait-state instance and a zero-wait instance
// share one clock/reset; expected responses are queued at accept and checked by a monitor.
module tb_dmem_responder;
    import mem_pkg::*;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   nTests;
    int   nFail;
    exp_t q2[$];
    exp_t q0[$];
    bit          prevV[2];
    bit          heldV[2];
    logic [31:0] heldD[2];
    logic        heldE[2];

    dmem_responder_if bus2 ();
    dmem_responder_if bus0 ();

    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    dmem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(0)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic driveReq(input int w, input bit v, input bit we, input logic [1:0] size,
                            input logic [31:0] addr, input logic [31:0] wdata);
        if (w == 0) begin
            bus2.req_valid = v; bus2.req_we = we; bus2.req_size = mem_size_t'(size);
            bus2.req_addr = addr; bus2.req_wdata = wdata;
        end else begin
            bus0.req_valid = v; bus0.req_we = we; bus0.req_size = mem_size_t'(size);
            bus0.req_addr = addr; bus0.req_wdata = wdata;
        end
    endtask

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic applyStimulus(input int w, input bit we, input logic [1:0] size,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [31:0] expRdata, input bit expErr,
                                 input bit push, output int acc);
        int   budget;
        bit   rdy;
        exp_t e;
        budget = 0;
        driveReq(w, 1'b1, we, size, addr, wdata);
        rdy = (w == 0) ? bus2.req_ready : bus0.req_ready;
        while (!rdy && budget < 50) begin
            @(negedge clk);
            budget++;
            rdy = (w == 0) ? bus2.req_ready : bus0.req_ready;
        end
        if (!rdy) checkOutput("accept_timeout", 32'(budget), 32'd0);
        acc = cyc;
        e.rdata = expRdata;
        e.err   = expErr;
        e.acc   = cyc;
        if (push && rdy) begin
            if (w == 0) q2.push_back(e);
            else        q0.push_back(e);
        end
        @(negedge clk);
        driveReq(w, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    endtask

    task automatic waitDrain(input int w);
        int budget;
        budget = 0;
        while (((w == 0) ? q2.size() : q0.size()) != 0 && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        if (budget >= 100) checkOutput("drain_timeout", 32'(budget), 32'd0);
    endtask

    task automatic monitorStep(input int w);
        logic        v, r, e;
        logic [31:0] d;
        int          lat;
        bit          have;
        exp_t        front;
        if (w == 0) begin
            v = bus2.rsp_valid; r = bus2.rsp_ready; d = bus2.rsp_rdata; e = bus2.rsp_err; lat = 3;
            have = (q2.size() != 0);
            if (have) front = q2[0];
        end else begin
            v = bus0.rsp_valid; r = bus0.rsp_ready; d = bus0.rsp_rdata; e = bus0.rsp_err; lat = 1;
            have = (q0.size() != 0);
            if (have) front = q0[0];
        end
        if (v && heldV[w]) begin
            checkOutput("stall_rdata_stable", d, heldD[w]);
            checkOutput("stall_err_stable", 32'(e), 32'(heldE[w]));
        end
        if (v && !prevV[w]) begin
            if (!have) checkOutput("unexpected_response", 32'd1, 32'd0);
            else       checkOutput("latency", 32'(cyc - front.acc), 32'(lat));
        end
        if (v && r && have) begin
            checkOutput("rsp_rdata", d, front.rdata);
            checkOutput("rsp_err", 32'(e), 32'(front.err));
            if (w == 0) void'(q2.pop_front());
            else        void'(q0.pop_front());
        end
        heldV[w] = v && !r;
        heldD[w] = d;
        heldE[w] = e;
        prevV[w] = v && !r;
    endtask

    always begin
        @(negedge clk);
        #1;
        if (!rst) begin
            monitorStep(0);
            monitorStep(1);
        end else begin
            for (int i = 0; i < 2; i++) begin
                prevV[i] = 1'b0;
                heldV[i] = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc;
        int accPrev;
        int budget;
        nTests = 0;
        nFail  = 0;
        rst    = 1'b0;
        driveReq(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        driveReq(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
        bus2.rsp_ready = 1'b1;
        bus0.rsp_ready = 1'b1;
        #1 rst = 1'b1;
        #2;
        checkOutput("reset_req_ready", 32'(bus2.req_ready), 32'd0);
        checkOutput("reset_rsp_valid", 32'(bus2.rsp_valid), 32'd0);
        checkOutput("reset_rsp_rdata", bus2.rsp_rdata, 32'h0);
        checkOutput("reset_rsp_err", 32'(bus2.rsp_err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("ready_at_release", 32'(bus2.req_ready), 32'd0);
        @(negedge clk);
        checkOutput("ready_after_release", 32'(bus2.req_ready), 32'd1);

        // Word store/load, byte merge and sub-word loads on the 2-wait instance.
        applyStimulus(0, 1, 2'b10, 32'h10, 32'hDEADBEEF, 32'h0, 0, 1, acc);
        applyStimulus(0, 0, 2'b10, 32'h10, 32'h0, 32'hDEADBEEF, 0, 1, acc);
        applyStimulus(0, 1, 2'b00, 32'h13, 32'h000000A5, 32'h0, 0, 1, acc);
        applyStimulus(0, 0, 2'b10, 32'h10, 32'h0, 32'hA5ADBEEF, 0, 1, acc);
        applyStimulus(0, 0, 2'b01, 32'h12, 32'h0, 32'h0000A5AD, 0, 1, acc);
        applyStimulus(0, 0, 2'b00, 32'h11, 32'h0, 32'h000000BE, 0, 1, acc);
        applyStimulus(0, 0, 2'b01, 32'h11, 32'h0, 32'h0, 1, 1, acc);
        applyStimulus(0, 1, 2'b10, 32'h12, 32'h12345678, 32'h0, 1, 1, acc);
        applyStimulus(0, 0, 2'b10, 32'h10, 32'h0, 32'hA5ADBEEF, 0, 1, acc);
        applyStimulus(0, 0, 2'b11, 32'h10, 32'h0, 32'h0, 1, 1, acc);
        applyStimulus(0, 0, 2'b10, 32'h1000, 32'h0, 32'h0, 1, 1, acc);
        applyStimulus(0, 1, 2'b10, 32'hFFC, 32'hCAFEF00D, 32'h0, 0, 1, acc);
        applyStimulus(0, 0, 2'b10, 32'hFFC, 32'h0, 32'hCAFEF00D, 0, 1, acc);
        applyStimulus(0, 1, 2'b10, 32'h0, 32'h55555555, 32'h0, 0, 1, acc);
        applyStimulus(0, 1, 2'b10, 32'h1000, 32'hFFFFFFFF, 32'h0, 1, 1, acc);
        applyStimulus(0, 0, 2'b10, 32'h0, 32'h0, 32'h55555555, 0, 1, acc);
        applyStimulus(0, 1, 2'b10, 32'h14, 32'h0, 32'h0, 0, 1, acc);
        applyStimulus(0, 1, 2'b01, 32'h16, 32'h00001234, 32'h0, 0, 1, acc);
        applyStimulus(0, 0, 2'b10, 32'h14, 32'h0, 32'h12340000, 0, 1, acc);
        applyStimulus(0, 1, 2'b00, 32'h14, 32'h00000077, 32'h0, 0, 1, acc);
        applyStimulus(0, 0, 2'b10, 32'h14, 32'h0, 32'h12340077, 0, 1, acc);
        waitDrain(0);

        // Backpressure: response must hold while rsp_ready is low.
        bus2.rsp_ready = 1'b0;
        applyStimulus(0, 0, 2'b10, 32'h10, 32'h0, 32'hA5ADBEEF, 0, 1, acc);
        budget = 0;
        while (!bus2.rsp_valid && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("bp_valid_seen", 32'(bus2.rsp_valid), 32'd1);
        repeat (5) begin
            @(negedge clk);
            #2;
            checkOutput("bp_req_ready", 32'(bus2.req_ready), 32'd0);
            checkOutput("bp_rsp_valid", 32'(bus2.rsp_valid), 32'd1);
        end
        @(negedge clk);
        bus2.rsp_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_idle_ready", 32'(bus2.req_ready), 32'd1);
        checkOutput("bp_idle_valid", 32'(bus2.rsp_valid), 32'd0);
        waitDrain(0);

        // Reset during the WAIT of a store drops it; the earlier value survives.
        applyStimulus(0, 1, 2'b10, 32'h20, 32'h0BADF00D, 32'h0, 0, 1, acc);
        applyStimulus(0, 0, 2'b10, 32'h20, 32'h0, 32'h0BADF00D, 0, 1, acc);
        waitDrain(0);
        applyStimulus(0, 1, 2'b10, 32'h20, 32'h11111111, 32'h0, 0, 0, acc);
        rst = 1'b1;
        #2;
        checkOutput("midrst_req_ready", 32'(bus2.req_ready), 32'd0);
        checkOutput("midrst_rsp_valid", 32'(bus2.rsp_valid), 32'd0);
        checkOutput("midrst_rsp_rdata", bus2.rsp_rdata, 32'h0);
        checkOutput("midrst_rsp_err", 32'(bus2.rsp_err), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_no_response", 32'(bus2.rsp_valid), 32'd0);
        applyStimulus(0, 0, 2'b10, 32'h20, 32'h0, 32'h0BADF00D, 0, 1, acc);
        waitDrain(0);

        // Zero-wait instance: back-to-back requests accepted every second cycle.
        applyStimulus(1, 1, 2'b10, 32'h40, 32'h01020304, 32'h0, 0, 1, accPrev);
        applyStimulus(1, 0, 2'b10, 32'h40, 32'h0, 32'h01020304, 0, 1, acc);
        checkOutput("b2b_spacing_1", 32'(acc - accPrev), 32'd2);
        accPrev = acc;
        applyStimulus(1, 1, 2'b00, 32'h42, 32'h000000FF, 32'h0, 0, 1, acc);
        checkOutput("b2b_spacing_2", 32'(acc - accPrev), 32'd2);
        accPrev = acc;
        applyStimulus(1, 0, 2'b10, 32'h40, 32'h0, 32'h01FF0304, 0, 1, acc);
        checkOutput("b2b_spacing_3", 32'(acc - accPrev), 32'd2);
        applyStimulus(1, 0, 2'b01, 32'h42, 32'h0, 32'h000001FF, 0, 1, acc);
        applyStimulus(1, 0, 2'b00, 32'h43, 32'h0, 32'h00000001, 0, 1, acc);
        waitDrain(1);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
